// File: rtl/serial_subtractor_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int unsigned SUB_W_DEFAULT = 8;

endpackage

// File: rtl/full_subtractor_bit.sv
// 1-bit full subtractor cell in borrow form: d = ai - bi - bin.
module full_subtractor_bit (
    input  logic ai,
    input  logic bi,
    input  logic bin,
    output logic d,
    output logic bo
);

    always_comb begin
        d  = ai ^ bi ^ bin;
        bo = (~ai & bi) | (~(ai ^ bi) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor (diff = a - b, LSB first) with start/busy/done handshake.
// Optional SUB_SIGNED_OVF_EN adds a two's-complement overflow output.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned W = SUB_W_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] diff,
    output logic         bout
`ifdef SUB_SIGNED_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int unsigned CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_t          state, state_nx;
    logic [W-1:0]    a_sh, b_sh;
    logic [W-2:0]    r_sh;
    logic [W-1:0]    r_nx;
    logic            brw;
    logic [CW-1:0]   cnt;
    logic            d, bo;
`ifdef SUB_SIGNED_OVF_EN
    logic            a_msb, b_msb;
`endif

    full_subtractor_bit u_bit (
        .ai  (a_sh[0]),
        .bi  (b_sh[0]),
        .bin (brw),
        .d   (d),
        .bo  (bo)
    );

    // r_sh keeps only the upper W-1 result bits; the last SHIFT cycle writes the
    // complete word straight into diff so it is already valid while done is high.
    assign r_nx = {d, r_sh};

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE:  if (start) state_nx = SHIFT;
            SHIFT: begin
                busy = 1'b1;
                if (cnt == LAST) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            r_sh  <= '0;
            brw   <= 1'b0;
            cnt   <= '0;
            diff  <= '0;
            bout  <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf   <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh <= a;
                        b_sh <= b;
                        r_sh <= '0;
                        brw  <= 1'b0;
                        cnt  <= '0;
`ifdef SUB_SIGNED_OVF_EN
                        a_msb <= a[W-1];
                        b_msb <= b[W-1];
`endif
                    end
                end
                SHIFT: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    r_sh <= r_nx[W-1:1];
                    brw  <= bo;
                    if (cnt == LAST) begin
                        cnt  <= '0;
                        diff <= r_nx;
                        bout <= bo;
`ifdef SUB_SIGNED_OVF_EN
                        ovf  <= (a_msb ^ b_msb) & (a_msb ^ d);
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor against an arithmetic reference model.
module tb_serial_subtractor;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [W-1:0] a, b, diff;
    logic         busy, done, bout;
`ifdef SUB_SIGNED_OVF_EN
    logic         ovf;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SUB_SIGNED_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one operation from an idle cycle; inj adds ignored start pulses and operand churn.
    task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input bit inj);
        int           r, sa, sb, sr;
        logic [W-1:0] ediff;
        logic         ebout, eovf;
        r     = int'(oa) - int'(ob);
        ediff = r[W-1:0];
        ebout = (oa < ob);
        sa    = int'($signed(oa));
        sb    = int'($signed(ob));
        sr    = sa - sb;
        eovf  = (sr >= (1 << (W - 1))) || (sr < -(1 << (W - 1)));
        a = oa; b = ob; start = 1'b1;
        tick;
        start = 1'b0;
        for (int c = 1; c <= W + 1; c++) begin
            if (inj) begin a = ~oa; b = oa ^ 8'h5A; end
            check("busy", busy, (c <= W));
            check("done", done, (c == W + 1));
            if (c == W + 1) begin
                check("diff", diff, ediff);
                check("bout", bout, ebout);
`ifdef SUB_SIGNED_OVF_EN
                check("ovf", ovf, eovf);
`endif
            end
            start = (inj && (c == 3 || c == W + 1));
            tick;
        end
        start = 1'b0;
        check("diff_hold", diff, ediff);
        check("bout_hold", bout, ebout);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        if (inj) begin
            for (int k = 0; k < 3; k++) begin
                check("no_requeue", {busy, done}, 0);
                tick;
            end
        end
    endtask

    initial begin
        int nd;
        logic [W-1:0] ra, rb;
        reset = 1'b1; start = 1'b0; a = '0; b = '0;
        tick; tick;
        reset = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_bout", bout, 0);
`ifdef SUB_SIGNED_OVF_EN
        check("rst_ovf", ovf, 0);
`endif
        tick;

        run_op(8'd5, 8'd3, 1'b0);
        run_op(8'd3, 8'd5, 1'b0);
        run_op(8'd0, 8'd255, 1'b0);
        run_op(8'hA5, 8'hA5, 1'b0);
        run_op(8'h80, 8'h01, 1'b0);
        run_op(8'h05, 8'h03, 1'b0);
        run_op(8'h7F, 8'hFF, 1'b0);
        run_op(8'd99, 8'd42, 1'b1);

        // Reset in cycle 4 of an operation aborts it.
        a = 8'd77; b = 8'd12; start = 1'b1;
        tick;
        start = 1'b0;
        tick; tick; tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_diff", diff, 0);
        check("abort_bout", bout, 0);
        nd = 0;
        for (int k = 0; k < W + 4; k++) begin
            if (done) nd++;
            tick;
        end
        check("abort_no_done", nd, 0);
        run_op(8'd200, 8'd100, 1'b0);

        // Continuous start: one result every W+2 cycles.
        a = 8'd10; b = 8'd1; start = 1'b1;
        tick;
        for (int c = 1; c <= 4 * (W + 2); c++) begin
            check("hold_done", done, ((c % (W + 2)) == W + 1));
            if (done) check("hold_diff", diff, 9);
            tick;
        end
        start = 1'b0;
        for (int k = 0; k < W + 3; k++) tick;

        for (int n = 0; n < 20; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            run_op(ra, rb, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
